// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one byte-strobed
// synchronous write port, optional same-cycle write forwarding and range checking.
module regfile_param #(
    parameter int               WIDTH     = 16,
    parameter int               NUM_REGS  = 8,
    parameter int               ADDR_W    = 3,
    parameter int               BYPASS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    read1RegSel,
    input  logic [ADDR_W-1:0]    read2RegSel,
    input  logic [ADDR_W-1:0]    writeRegSel,
    input  logic [WIDTH-1:0]     writeData,
    input  logic                 writeEn,
    input  logic [WIDTH/8-1:0]   writeStrb,
    output logic [WIDTH-1:0]     read1Data,
    output logic [WIDTH-1:0]     read2Data,
    output logic                 err
);

    localparam int              LANES     = WIDTH / 8;
    localparam logic [ADDR_W:0] REG_COUNT = (ADDR_W + 1)'(NUM_REGS);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    logic [WIDTH-1:0] writeOld;
    logic [WIDTH-1:0] writeMerged;
    logic [WIDTH-1:0] read1Stored;
    logic [WIDTH-1:0] read2Stored;
    logic             writeInRange;
    logic             read1InRange;
    logic             read2InRange;
    logic             writeHit;
    logic             bypass1;
    logic             bypass2;

    assign writeInRange = {1'b0, writeRegSel} < REG_COUNT;
    assign read1InRange = {1'b0, read1RegSel} < REG_COUNT;
    assign read2InRange = {1'b0, read2RegSel} < REG_COUNT;
    assign writeHit     = rst & writeEn & writeInRange;

    // Out-of-range selects match no entry, so they read back as zero.
    always_comb begin
        writeOld    = '0;
        read1Stored = '0;
        read2Stored = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (writeRegSel == ADDR_W'(r)) writeOld    = regs_q[r];
            if (read1RegSel == ADDR_W'(r)) read1Stored = regs_q[r];
            if (read2RegSel == ADDR_W'(r)) read2Stored = regs_q[r];
        end
    end

    always_comb begin
        writeMerged = writeOld;
        for (int i = 0; i < LANES; i++) begin
            if (writeStrb[i]) writeMerged[8*i +: 8] = writeData[8*i +: 8];
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (writeEn && writeInRange && (writeRegSel == ADDR_W'(r))) begin
                regs_d[r] = writeMerged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Forwarding is gated by rst through writeHit, so reset reads show stored values.
    assign bypass1 = (BYPASS != 0) && writeHit && (read1RegSel == writeRegSel);
    assign bypass2 = (BYPASS != 0) && writeHit && (read2RegSel == writeRegSel);

    assign read1Data = bypass1 ? writeMerged : read1Stored;
    assign read2Data = bypass2 ? writeMerged : read2Stored;

    assign err = (writeEn & ~writeInRange) | ~read1InRange | ~read2InRange;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: three builds (default with bypass, 6-entry
// without bypass, 32-bit/16-entry with non-zero reset value) against a behavioural model.
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [2:0]  aR1, aR2, aWs;
    logic [15:0] aWd;
    logic        aWe;
    logic [1:0]  aStrb;
    logic [15:0] aD1, aD2;
    logic        aErr;

    logic [2:0]  bR1, bR2, bWs;
    logic [15:0] bWd;
    logic        bWe;
    logic [1:0]  bStrb;
    logic [15:0] bD1, bD2;
    logic        bErr;

    logic [3:0]  cR1, cR2, cWs;
    logic [31:0] cWd;
    logic        cWe;
    logic [3:0]  cStrb;
    logic [31:0] cD1, cD2;
    logic        cErr;

    regfile_param #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3), .BYPASS(1), .RESET_VAL(16'h0000)) dutA (
        .clk(clk), .rst(rst),
        .read1RegSel(aR1), .read2RegSel(aR2), .writeRegSel(aWs),
        .writeData(aWd), .writeEn(aWe), .writeStrb(aStrb),
        .read1Data(aD1), .read2Data(aD2), .err(aErr)
    );

    regfile_param #(.WIDTH(16), .NUM_REGS(6), .ADDR_W(3), .BYPASS(0), .RESET_VAL(16'h0000)) dutB (
        .clk(clk), .rst(rst),
        .read1RegSel(bR1), .read2RegSel(bR2), .writeRegSel(bWs),
        .writeData(bWd), .writeEn(bWe), .writeStrb(bStrb),
        .read1Data(bD1), .read2Data(bD2), .err(bErr)
    );

    regfile_param #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(4), .BYPASS(1), .RESET_VAL(32'hDEADBEEF)) dutC (
        .clk(clk), .rst(rst),
        .read1RegSel(cR1), .read2RegSel(cR2), .writeRegSel(cWs),
        .writeData(cWd), .writeEn(cWe), .writeStrb(cStrb),
        .read1Data(cD1), .read2Data(cD2), .err(cErr)
    );

    int checks = 0;
    int passes = 0;

    logic [31:0] memA [16];
    logic [31:0] memB [16];
    logic [31:0] memC [16];

    typedef struct {
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [2:0]  ws;
        logic [15:0] wd;
        logic        we;
        logic [1:0]  strb;
        logic [15:0] exp1;
        logic [15:0] exp2;
    } vecT;

    vecT vecs [16];

    // Byte-lane merge: strobed lanes from the new word, the rest from the old one.
    function automatic logic [31:0] mergeLanes(input logic [31:0] oldV, input logic [31:0] newV,
                                               input logic [3:0] strb);
        logic [31:0] res;
        res = oldV;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = newV[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] expRead(input int sel, input int n, input bit byp, input logic rstV,
                                            input logic we, input int ws, input logic [31:0] wd,
                                            input logic [3:0] strb, input logic [31:0] stored,
                                            input logic [31:0] storedW);
        if (sel >= n) return 32'h0;
        if (byp && rstV && we && (ws < n) && (sel == ws)) return mergeLanes(storedW, wd, strb);
        return stored;
    endfunction

    function automatic logic expErr(input int n, input logic we, input int ws, input int r1, input int r2);
        return (we && (ws >= n)) || (r1 >= n) || (r2 >= n);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            memA[i] = 32'h0;
            memB[i] = 32'h0;
            memC[i] = 32'hDEADBEEF;
        end
    endtask

    // Advances one clock; the model commits writes seen at the rising edge.
    task automatic clockStep();
        @(posedge clk);
        if (rst === 1'b1) begin
            if (aWe && int'(aWs) < 8)  memA[aWs] = mergeLanes(memA[aWs], {16'h0, aWd}, {2'b00, aStrb});
            if (bWe && int'(bWs) < 6)  memB[bWs] = mergeLanes(memB[bWs], {16'h0, bWd}, {2'b00, bStrb});
            if (cWe && int'(cWs) < 16) memC[cWs] = mergeLanes(memC[cWs], cWd, cStrb);
        end
        @(negedge clk);
    endtask

    task automatic applyStimulusA(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] ws,
                                  input logic [15:0] wd, input logic we, input logic [1:0] strb);
        aR1 = r1; aR2 = r2; aWs = ws; aWd = wd; aWe = we; aStrb = strb;
    endtask

    task automatic applyStimulusB(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] ws,
                                  input logic [15:0] wd, input logic we, input logic [1:0] strb);
        bR1 = r1; bR2 = r2; bWs = ws; bWd = wd; bWe = we; bStrb = strb;
    endtask

    task automatic applyStimulusC(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] ws,
                                  input logic [31:0] wd, input logic we, input logic [3:0] strb);
        cR1 = r1; cR2 = r2; cWs = ws; cWd = wd; cWe = we; cStrb = strb;
    endtask

    task automatic checkB(input string name, input logic [15:0] e1, input logic [15:0] e2, input logic eErr);
        checkOutput({name, ".read1"}, {16'h0, bD1}, {16'h0, e1});
        checkOutput({name, ".read2"}, {16'h0, bD2}, {16'h0, e2});
        checkOutput({name, ".err"}, {31'h0, bErr}, {31'h0, eErr});
    endtask

    task automatic checkModels(input string tag);
        checkOutput({tag, ".A.read1"}, {16'h0, aD1},
                    expRead(int'(aR1), 8, 1'b1, rst, aWe, int'(aWs), {16'h0, aWd}, {2'b00, aStrb},
                            memA[aR1], memA[aWs]));
        checkOutput({tag, ".A.read2"}, {16'h0, aD2},
                    expRead(int'(aR2), 8, 1'b1, rst, aWe, int'(aWs), {16'h0, aWd}, {2'b00, aStrb},
                            memA[aR2], memA[aWs]));
        checkOutput({tag, ".A.err"}, {31'h0, aErr},
                    {31'h0, expErr(8, aWe, int'(aWs), int'(aR1), int'(aR2))});
        checkOutput({tag, ".B.read1"}, {16'h0, bD1},
                    expRead(int'(bR1), 6, 1'b0, rst, bWe, int'(bWs), {16'h0, bWd}, {2'b00, bStrb},
                            memB[bR1], memB[bWs]));
        checkOutput({tag, ".B.read2"}, {16'h0, bD2},
                    expRead(int'(bR2), 6, 1'b0, rst, bWe, int'(bWs), {16'h0, bWd}, {2'b00, bStrb},
                            memB[bR2], memB[bWs]));
        checkOutput({tag, ".B.err"}, {31'h0, bErr},
                    {31'h0, expErr(6, bWe, int'(bWs), int'(bR1), int'(bR2))});
    endtask

    initial begin
        // Directed vectors for the bypassing 16-bit build, starting from an all-zero file.
        vecs = '{
            '{3'd3, 3'd0, 3'd3, 16'h1234, 1'b1, 2'b11, 16'h1234, 16'h0000},
            '{3'd5, 3'd3, 3'd5, 16'hBEEF, 1'b1, 2'b11, 16'hBEEF, 16'h1234},
            '{3'd5, 3'd3, 3'd0, 16'h0000, 1'b0, 2'b00, 16'hBEEF, 16'h1234},
            '{3'd2, 3'd5, 3'd2, 16'hAAAA, 1'b1, 2'b11, 16'hAAAA, 16'hBEEF},
            '{3'd2, 3'd2, 3'd2, 16'h1155, 1'b1, 2'b01, 16'hAA55, 16'hAA55},
            '{3'd2, 3'd0, 3'd0, 16'h0000, 1'b0, 2'b00, 16'hAA55, 16'h0000},
            '{3'd1, 3'd0, 3'd1, 16'h0001, 1'b1, 2'b11, 16'h0001, 16'h0000},
            '{3'd6, 3'd1, 3'd6, 16'h0006, 1'b1, 2'b11, 16'h0006, 16'h0001},
            '{3'd1, 3'd6, 3'd6, 16'h0F0F, 1'b1, 2'b11, 16'h0001, 16'h0F0F},
            '{3'd1, 3'd6, 3'd0, 16'h0000, 1'b0, 2'b00, 16'h0001, 16'h0F0F},
            '{3'd4, 3'd4, 3'd4, 16'hFFFF, 1'b1, 2'b00, 16'h0000, 16'h0000},
            '{3'd4, 3'd3, 3'd0, 16'h0000, 1'b0, 2'b00, 16'h0000, 16'h1234},
            '{3'd3, 3'd2, 3'd3, 16'hFFFF, 1'b0, 2'b11, 16'h1234, 16'hAA55},
            '{3'd3, 3'd7, 3'd0, 16'h0000, 1'b0, 2'b00, 16'h1234, 16'h0000},
            '{3'd2, 3'd5, 3'd2, 16'h33CC, 1'b1, 2'b10, 16'h3355, 16'hBEEF},
            '{3'd2, 3'd6, 3'd0, 16'h0000, 1'b0, 2'b00, 16'h3355, 16'h0F0F}
        };

        rst = 1'b0;
        applyStimulusA(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'b00);
        applyStimulusB(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'b00);
        applyStimulusC(4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 4'b0000);
        modelReset();
        @(negedge clk);

        // Reset contents on every build while rst is held low.
        for (int i = 0; i < 16; i++) begin
            cR1 = 4'(i);
            cR2 = 4'(15 - i);
            aR1 = 3'(i % 8);
            bR1 = 3'(i % 6);
            #1;
            checkOutput($sformatf("rstC[%0d].read1", i), cD1, 32'hDEADBEEF);
            checkOutput($sformatf("rstC[%0d].read2", i), cD2, 32'hDEADBEEF);
            checkOutput($sformatf("rstA[%0d].read1", i), {16'h0, aD1}, 32'h0);
            checkOutput($sformatf("rstB[%0d].read1", i), {16'h0, bD1}, 32'h0);
        end
        applyStimulusA(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'b00);
        applyStimulusB(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'b00);
        applyStimulusC(4'd0, 4'd0, 4'd0, 32'h0, 1'b0, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulusA(vecs[i].r1, vecs[i].r2, vecs[i].ws, vecs[i].wd, vecs[i].we, vecs[i].strb);
            #1;
            checkOutput($sformatf("tblA[%0d].read1", i), {16'h0, aD1}, {16'h0, vecs[i].exp1});
            checkOutput($sformatf("tblA[%0d].read2", i), {16'h0, aD2}, {16'h0, vecs[i].exp2});
            checkOutput($sformatf("tblA[%0d].err", i), {31'h0, aErr}, 32'h0);
            clockStep();
        end
        applyStimulusA(3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'b00);

        // 6-entry build without forwarding: old data until the edge, range errors.
        applyStimulusB(3'd5, 3'd0, 3'd5, 16'hBEEF, 1'b1, 2'b11); #1;
        checkB("noBypassOld", 16'h0000, 16'h0000, 1'b0); clockStep();
        applyStimulusB(3'd5, 3'd0, 3'd0, 16'h0000, 1'b0, 2'b00); #1;
        checkB("noBypassNew", 16'hBEEF, 16'h0000, 1'b0); clockStep();
        applyStimulusB(3'd5, 3'd0, 3'd7, 16'hFFFF, 1'b1, 2'b11); #1;
        checkB("oorWrite7", 16'hBEEF, 16'h0000, 1'b1); clockStep();
        applyStimulusB(3'd5, 3'd0, 3'd6, 16'hFFFF, 1'b1, 2'b11); #1;
        checkB("oorWrite6", 16'hBEEF, 16'h0000, 1'b1); clockStep();
        applyStimulusB(3'd6, 3'd5, 3'd0, 16'h0000, 1'b0, 2'b00); #1;
        checkB("oorRead6", 16'h0000, 16'hBEEF, 1'b1); clockStep();
        for (int i = 0; i < 6; i++) begin
            applyStimulusB(3'(i), 3'(5 - i), 3'd0, 16'h0000, 1'b0, 2'b00); #1;
            checkB($sformatf("unchanged[%0d]", i), (i == 5) ? 16'hBEEF : 16'h0000,
                   (i == 0) ? 16'hBEEF : 16'h0000, 1'b0);
            clockStep();
        end
        applyStimulusB(3'd0, 3'd0, 3'd7, 16'hFFFF, 1'b0, 2'b11); #1;
        checkB("oorIdleWrite", 16'h0000, 16'h0000, 1'b0); clockStep();
        applyStimulusB(3'd0, 3'd7, 3'd0, 16'h0000, 1'b0, 2'b00); #1;
        checkB("oorRead7", 16'h0000, 16'h0000, 1'b1); clockStep();
        applyStimulusB(3'd5, 3'd0, 3'd5, 16'h0011, 1'b1, 2'b01); #1;
        checkB("strbOld", 16'hBEEF, 16'h0000, 1'b0); clockStep();
        applyStimulusB(3'd5, 3'd0, 3'd0, 16'h0000, 1'b0, 2'b00); #1;
        checkB("strbNew", 16'hBE11, 16'h0000, 1'b0); clockStep();

        // 32-bit build: top-lane write over the reset pattern.
        applyStimulusC(4'd15, 4'd0, 4'd15, 32'h12000000, 1'b1, 4'b1000); #1;
        checkOutput("wideBypass.read1", cD1, 32'h12ADBEEF);
        checkOutput("wideBypass.read2", cD2, 32'hDEADBEEF);
        checkOutput("wideBypass.err", {31'h0, cErr}, 32'h0);
        clockStep();
        applyStimulusC(4'd15, 4'd14, 4'd0, 32'h0, 1'b0, 4'b0000); #1;
        checkOutput("wideStored.read1", cD1, 32'h12ADBEEF);
        checkOutput("wideStored.read2", cD2, 32'hDEADBEEF);
        clockStep();

        // Mid-cycle reset pulse: contents clear at once, forwarding and writes suppressed.
        applyStimulusA(3'd3, 3'd2, 3'd3, 16'hFFFF, 1'b1, 2'b11); #1;
        checkOutput("preReset.read1", {16'h0, aD1}, 32'h0000FFFF);
        checkOutput("preReset.read2", {16'h0, aD2}, 32'h00003355);
        #1;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("inReset.read1", {16'h0, aD1}, 32'h0);
        checkOutput("inReset.read2", {16'h0, aD2}, 32'h0);
        checkOutput("inReset.wide", cD1, 32'hDEADBEEF);
        clockStep();
        #1;
        checkOutput("resetHoldsWrite", {16'h0, aD1}, 32'h0);
        applyStimulusA(3'd3, 3'd2, 3'd0, 16'h0000, 1'b0, 2'b00);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("afterRelease", {16'h0, aD1}, 32'h0);
        clockStep();
        #1;
        checkOutput("afterReleaseEdge", {16'h0, aD1}, 32'h0);
        @(negedge clk);

        // Randomised traffic on both 16-bit builds, with occasional reset pulses.
        for (int it = 0; it < 300; it++) begin
            rst = ($urandom_range(0, 15) != 0);
            if (!rst) modelReset();
            aR1 = 3'($urandom_range(0, 7)); aR2 = 3'($urandom_range(0, 7)); aWs = 3'($urandom_range(0, 7));
            aWd = 16'($urandom); aWe = 1'($urandom_range(0, 1)); aStrb = 2'($urandom_range(0, 3));
            bR1 = 3'($urandom_range(0, 7)); bR2 = 3'($urandom_range(0, 7)); bWs = 3'($urandom_range(0, 7));
            bWd = 16'($urandom); bWe = 1'($urandom_range(0, 1)); bStrb = 2'($urandom_range(0, 3));
            #1;
            checkModels($sformatf("rnd%0d", it));
            clockStep();
        end
        rst = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised multi-register storage block; next generation of the single 16-bit write-enabled register.
- Holds NUM_REGS registers of WIDTH bits, with two combinational read ports and one synchronous write port.
- Adds per-byte write strobes, optional write-to-read bypass, and out-of-range address error flagging.
- Serves as the CPU register file between decode and execute.

Parameters:
- WIDTH, 16, bits per register; must be a multiple of 8.
- NUM_REGS, 8, number of registers; 2..2**ADDR_W.
- ADDR_W, 3, width of every register-select port.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored value only.
- RESET_VAL, 0, value loaded into every register on reset (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- read1RegSel  in  ADDR_W  read port 1 register index.
- read2RegSel  in  ADDR_W  read port 2 register index.
- writeRegSel  in  ADDR_W  write port register index.
- writeData  in  WIDTH  write data.
- writeEn  in  1  write request.
- writeStrb  in  WIDTH/8  byte-lane enables for the write; bit i covers bits [8i+7:8i].
- read1Data  out  WIDTH  read port 1 data.
- read2Data  out  WIDTH  read port 2 data.
- err  out  1  illegal access indication (combinational).

Behaviour:
- Reset:
  - rst low asynchronously forces every register to RESET_VAL, independent of clk; held while low.
  - Outputs during reset: read data = RESET_VAL for in-range selects, bypass suppressed; err follows its rules below.
  - Writes are ignored while rst low.
  - Release of rst takes effect at the next rising edge; no write is lost or duplicated on the release edge if writeEn is sampled high then.
- Write:
  - Occurs on the rising clk edge when rst high, writeEn=1 and writeRegSel < NUM_REGS.
  - For each lane i with writeStrb[i]=1, that byte takes writeData; lanes with writeStrb[i]=0 hold their value.
  - writeStrb all-zero is a legal no-op.
  - Write latency: new value is visible via stored-data reads in the cycle after the edge.
- Read:
  - Purely combinational from the select to the data output; zero latency.
  - Both ports are independent and may address the same register.
- Bypass (BYPASS=1):
  - Applies when rst is high, writeEn=1, writeRegSel < NUM_REGS and readNRegSel == writeRegSel.
  - readNData returns the merged value: strobed lanes from writeData, other lanes from the stored register.
  - Both ports bypass independently.
- No bypass (BYPASS=0): reads always return stored contents, so the old value is seen until after the edge.
- Out of range:
  - A select >= NUM_REGS on a read port returns all zeros on that port.
  - On the write port, the write is dropped and no register changes.
- err:
  - err = (writeEn & writeRegSel>=NUM_REGS) | (read1RegSel>=NUM_REGS) | (read2RegSel>=NUM_REGS).
  - Combinational, not sticky.
  - When NUM_REGS == 2**ADDR_W, err is constant 0.
- No internal state other than register contents; no handshake; one write per cycle max.

Test Plan:
1. Reset: load R3=0x1234, then pulse rst low mid-cycle without a clk edge -> read1Data(R3) = 0x0000 immediately; stays 0x0000 after rst rises until written.
2. Full write: writeEn=1, writeRegSel=5, writeData=0xBEEF, writeStrb=2'b11; read1RegSel=5 -> BYPASS=1: read1Data=0xBEEF in the same cycle. BYPASS=0: old value in the same cycle, 0xBEEF after the edge.
3. Byte strobe: R2=0xAAAA, then write 0x1155 with strobe 2'b01 -> after the edge R2=0xAA55. Same-cycle bypass read also shows 0xAA55.
4. Dual read / write conflict: R1=0x0001, R6=0x0006; read1=1, read2=6 while writing R6=0x0F0F, strobe 11 -> read1=0x0001, read2=0x0F0F (bypass); next cycle both reads stable.
5. Out of range (NUM_REGS=6, ADDR_W=3): write sel 7 data 0xFFFF -> err=1, all registers unchanged. Read sel 6 -> read data 0x0000, err=1. All selects in range -> err=0.
6. Parametrised build (WIDTH=32, NUM_REGS=16, ADDR_W=4, RESET_VAL=0xDEADBEEF): after reset all 16 reads = 0xDEADBEEF. Write R15 strobe 4'b1000 data 0x12000000 -> R15=0x12ADBEEF.
